// File: rtl/d_ff_pkg.sv
// d_ff_pkg: shared defaults and width helper for the d_ff pipeline family.
package d_ff_pkg;
    localparam int DEF_N = 8;
    localparam int DEF_DEPTH = 4;
    function automatic int clog2p1(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/d_ff_stage.sv
// d_ff_stage: one pipeline register with a valid bit; holds data when not loaded.
module d_ff_stage
    import d_ff_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         load,
    input  logic         up_valid,
    input  logic [N-1:0] up_data,
    output logic         valid,
    output logic [N-1:0] data
);
    logic         valid_q, valid_d;
    logic [N-1:0] data_q, data_d;
    // data only moves with a valid upstream so bubbles never pull in unqualified input
    always_comb begin
        valid_d = load ? up_valid : valid_q;
        data_d  = (load && up_valid) ? up_data : data_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/d_ff_pipe.sv
// d_ff_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse and flush.
module d_ff_pipe
    import d_ff_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int DEPTH = DEF_DEPTH,
    localparam int OCC_W = clog2p1(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     q,
    output logic [N-1:0]     qbar,
    output logic [OCC_W-1:0] occupancy
);
    logic [DEPTH-1:0] v;
    logic [N-1:0]     data [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [OCC_W-1:0] occ;
    // a stage can load if it is empty or everything ahead of it moves
    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) rdy[i] = ~v[i] | rdy[i + 1];
    end
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) occ = occ + OCC_W'(v[i]);
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic         up_v;
        logic [N-1:0] up_d;
        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = d;
        end else begin : g_body
            assign up_v = v[i - 1];
            assign up_d = data[i - 1];
        end
        d_ff_stage #(.N(N)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .load    (rdy[i]),
            .up_valid(up_v),
            .up_data (up_d),
            .valid   (v[i]),
            .data    (data[i])
        );
    end
    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH - 1];
    assign q         = data[DEPTH - 1];
    assign qbar      = ~data[DEPTH - 1];
    assign occupancy = occ;
endmodule

// File: tb/tb_d_ff_pipe.sv
// tb_d_ff_pipe: scoreboard bench; accepted inputs queue up and must leave in order.
module tb_d_ff_pipe;
    localparam int N = 8;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [N-1:0] d = '0, q, qbar, q_inv, qv;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    int checks = 0, errors = 0, nout = 0, n0 = 0;
    logic [N-1:0] sb[$];

    d_ff_pipe #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .qbar(qbar), .occupancy(occupancy)
    );

    always #5 clk = ~clk;
    assign q_inv = ~q;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [N-1:0] val, output bit acc);
        d = val;
        in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready;
        step();
    endtask

    task automatic push(input logic [N-1:0] val);
        bit acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) offer(val, acc);
        chk("push_accepted", int'(acc), 1);
        in_valid = 1'b0;
    endtask

    // stimulus side: record what the pipe accepted, drop everything on reset/flush
    always @(negedge clk) begin
        #1;
        if (reset || flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(d);
    end

    // monitor: occupancy equals items in flight, outputs leave in FIFO order
    always @(negedge clk) begin
        if (!reset) begin
            chk("occupancy", int'(occupancy), sb.size());
            chk("qbar", int'(qbar), int'(q_inv));
            chk("in_ready", int'(in_ready), int'(!flush && (sb.size() < DEPTH || out_ready)));
            if (sb.size() == 0) chk("idle_out_valid", int'(out_valid), 0);
            if (out_valid && out_ready) begin
                nout++;
                if (sb.size() != 0) chk("q_order", int'(q), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        in_valid = 1'b1;
        d = 'x;
        repeat (2) step();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("rst_q", int'(q), 0);
        chk("rst_qbar", int'(qbar), 'hFF);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_occ", int'(occupancy), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push(N'(k));
            if (k == 2) chk("stream_early", int'(out_valid), 0);
            if (k == 3) begin
                chk("stream_first_valid", int'(out_valid), 1);
                chk("stream_first_q", int'(q), 0);
            end
            if (k >= 3) chk("stream_occ", int'(occupancy), DEPTH);
            if (k == 4) chk("stream_second_q", int'(q), 1);
        end
        repeat (6) step();

        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(8'h10 + N'(k));
        chk("bp_occ", int'(occupancy), DEPTH);
        d = 8'h14;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", int'(in_ready), 0);
        step();
        n0 = nout;
        out_ready = 1'b1;
        push(8'h14);
        push(8'h15);
        repeat (4) step();
        chk("bp_no_gaps", nout - n0, 6);
        repeat (4) step();

        out_ready = 1'b0;
        push(8'hA5);
        repeat (2) step();
        push(8'h5A);
        repeat (4) step();
        chk("bubble_occ", int'(occupancy), 2);
        chk("bubble_out_valid", int'(out_valid), 1);
        chk("bubble_q", int'(q), 'hA5);
        chk("bubble_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        repeat (6) step();

        out_ready = 1'b0;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        chk("flush_pre_occ", int'(occupancy), 3);
        flush = 1'b1;
        in_valid = 1'b1;
        d = 8'h77;
        @(negedge clk);
        chk("flush_in_ready", int'(in_ready), 0);
        qv = q;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", int'(occupancy), 0);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_q_hold", int'(q), int'(qv));
        out_ready = 1'b1;
        repeat (6) step();
        chk("flush_q_later", int'(q), int'(qv));

        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(8'h61 + N'(k));
        chk("mid_full_occ", int'(occupancy), DEPTH);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_q", int'(q), 0);
        chk("mid_rst_qbar", int'(qbar), 'hFF);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_occ", int'(occupancy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        push(8'h01);
        repeat (2) step();
        chk("mid_lat_early", int'(out_valid), 0);
        step();
        chk("mid_lat_valid", int'(out_valid), 1);
        chk("mid_lat_q", int'(q), 1);
        repeat (4) step();

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            flush = !reset && ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            d = N'($urandom);
            out_ready = !reset && ($urandom_range(0, 2) != 0);
            step();
        end
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 4) step();
        chk("drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
